// File: rtl/sdpram_fwft_fifo.sv
// First-word-fall-through FIFO on an inferred simple-dual-port RAM.
// Ports: clk, rst_n (sync, active-low), i_wr_en/i_wr_data/o_wr_ready push side,
// o_rd_data/o_rd_valid/i_rd_ready pop side, o_count, o_almost_full,
// o_almost_empty, o_overflow (sticky dropped-push flag).
module sdpram_fwft_fifo #(
    parameter int    DEPTH         = 32,
    parameter int    DW            = 32,
    parameter int    AW            = $clog2(DEPTH),
    parameter int    CW            = $clog2(DEPTH + 1),
    parameter int    READ_LATENCY  = 1,
    parameter int    AFULL_THRESH  = DEPTH - 4,
    parameter int    AEMPTY_THRESH = 4,
    parameter string MEMORY_TYPE   = "block"
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ready,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    input  logic          i_rd_ready,
    output logic [CW-1:0] o_count,
    output logic          o_almost_full,
    output logic          o_almost_empty,
    output logic          o_overflow
);

    // Skid buffer holds every word that can be in flight plus the head.
    localparam int SK = READ_LATENCY + 1;

    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           r_ram_cnt;
    logic [READ_LATENCY-1:0] r_tag;
    logic [DW-1:0]           r_skid [4];
    logic [1:0]              r_skid_cnt;
    logic                    r_rd_valid;
    logic                    r_wr_ready;
    logic                    r_afull;
    logic                    r_aempty;
    logic                    r_ovf;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_issue;
    logic                    w_land;
    logic [1:0]              w_in_flight;
    logic [2:0]              w_credit;
    logic [1:0]              w_sk_idx;
    logic [1:0]              w_skid_nxt;
    logic [CW-1:0]           w_count_nxt;
    logic [CW-1:0]           w_ram_cnt_nxt;
    logic [DW-1:0]           w_mem_q;
    logic [DW-1:0]           w_ram_q;

    always_comb begin
        w_push = i_wr_en & r_wr_ready;
        w_pop  = r_rd_valid & i_rd_ready;
        w_land = r_tag[READ_LATENCY-1];

        w_in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_in_flight = w_in_flight + {1'b0, r_tag[i]};
        end

        // Credit counts the pop of this cycle so a freed slot is refilled
        // immediately; otherwise streaming would bubble every other cycle.
        w_credit = {1'b0, w_in_flight} + {1'b0, r_skid_cnt} - {2'b0, w_pop};
        w_issue  = (r_ram_cnt != '0) && (w_credit < 3'(SK));

        // Landing slot is computed after the pop shift.
        w_sk_idx   = r_skid_cnt - {1'b0, w_pop};
        w_skid_nxt = w_sk_idx + {1'b0, w_land};

        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase

        w_ram_cnt_nxt = r_ram_cnt;
        unique case ({w_push, w_issue})
            2'b10:   w_ram_cnt_nxt = r_ram_cnt + CW'(1);
            2'b01:   w_ram_cnt_nxt = r_ram_cnt - CW'(1);
            default: w_ram_cnt_nxt = r_ram_cnt;
        endcase
    end

    // RAM: write port plus registered read port, no reset on the array.
    if (MEMORY_TYPE == "distributed") begin : g_dist
        (* ram_style = "distributed" *) logic [DW-1:0] r_mem [DEPTH];
        logic [DW-1:0] r_q;
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wptr] <= i_wr_data;
            if (w_issue) r_q <= r_mem[r_rptr];
        end
        assign w_mem_q = r_q;
    end else begin : g_block
        (* ram_style = "block" *) logic [DW-1:0] r_mem [DEPTH];
        logic [DW-1:0] r_q;
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wptr] <= i_wr_data;
            if (w_issue) r_q <= r_mem[r_rptr];
        end
        assign w_mem_q = r_q;
    end

    // Optional output register of the RAM for a two-cycle read.
    if (READ_LATENCY == 2) begin : g_rl2
        logic [DW-1:0] r_q2;
        always_ff @(posedge clk) begin
            r_q2 <= w_mem_q;
        end
        assign w_ram_q = r_q2;
    end else begin : g_rl1
        assign w_ram_q = w_mem_q;
    end

    // Skid data: shift-down FIFO, entry 0 is the head word.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            for (int i = 0; i < 3; i++) begin
                r_skid[i] <= r_skid[i+1];
            end
        end
        if (w_land) r_skid[w_sk_idx] <= w_ram_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ram_cnt  <= '0;
            r_tag      <= '0;
            r_skid_cnt <= '0;
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_issue) r_rptr <= r_rptr + AW'(1);
            r_tag[0] <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_count    <= w_count_nxt;
            r_ram_cnt  <= w_ram_cnt_nxt;
            r_skid_cnt <= w_skid_nxt;
            r_rd_valid <= (w_skid_nxt != 2'd0);
            r_wr_ready <= (w_count_nxt != CW'(DEPTH));
            r_afull    <= (w_count_nxt >= CW'(AFULL_THRESH));
            r_aempty   <= (w_count_nxt <= CW'(AEMPTY_THRESH));
            if (i_wr_en && !r_wr_ready) r_ovf <= 1'b1;
        end
    end

    assign o_wr_ready     = r_wr_ready;
    assign o_rd_data      = r_skid[0];
    assign o_rd_valid     = r_rd_valid;
    assign o_count        = r_count;
    assign o_almost_full  = r_afull;
    assign o_almost_empty = r_aempty;
    assign o_overflow     = r_ovf;

endmodule

// File: tb/tb_sdpram_fwft_fifo.sv
// Self-checking bench for sdpram_fwft_fifo, READ_LATENCY 1 and 2 instances.
// Scoreboard queue holds pushed words; pops are compared in order.
module tb_sdpram_fwft_fifo;

    localparam int DEPTH = 32;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;

    logic        clk = 1'b0;
    logic        rst_n    [2];
    logic        wr_en    [2];
    logic [31:0] wr_data  [2];
    logic        rd_ready [2];
    logic        wr_ready [2];
    logic [31:0] rd_data  [2];
    logic        rd_valid [2];
    logic [5:0]  count    [2];
    logic        afull    [2];
    logic        aempty   [2];
    logic        ovf      [2];

    int          tests = 0;
    int          fails = 0;
    int          sel   = 0;
    int          rl    = 1;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    sdpram_fwft_fifo #(.DEPTH(DEPTH), .DW(32), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[0]),
        .i_wr_en(wr_en[0]), .i_wr_data(wr_data[0]), .o_wr_ready(wr_ready[0]),
        .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .i_rd_ready(rd_ready[0]),
        .o_count(count[0]), .o_almost_full(afull[0]),
        .o_almost_empty(aempty[0]), .o_overflow(ovf[0])
    );

    sdpram_fwft_fifo #(.DEPTH(DEPTH), .DW(32), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n[1]),
        .i_wr_en(wr_en[1]), .i_wr_data(wr_data[1]), .o_wr_ready(wr_ready[1]),
        .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .i_rd_ready(rd_ready[1]),
        .o_count(count[1]), .o_almost_full(afull[1]),
        .o_almost_empty(aempty[1]), .o_overflow(ovf[1])
    );

    // One clock: drive, check flags against model at negedge, update
    // scoreboard, then advance to just after the next rising edge.
    task automatic step(input logic we, input logic [31:0] wd, input logic rr);
        logic [31:0] e;
        bit          acc_w;
        wr_en[sel]    = we;
        wr_data[sel]  = wd;
        rd_ready[sel] = rr;
        @(negedge clk);
        tests++;
        if (count[sel] !== 6'(m_cnt) || wr_ready[sel] !== (m_cnt != DEPTH) ||
            afull[sel] !== (m_cnt >= AF) || aempty[sel] !== (m_cnt <= AE) ||
            ovf[sel] !== m_ovf) begin
            fails++;
            $display("FAIL state rl=%0d count=%0d exp=%0d rdy=%b afull=%b aempty=%b ovf=%b exp_ovf=%b",
                     rl, count[sel], m_cnt, wr_ready[sel], afull[sel], aempty[sel], ovf[sel], m_ovf);
        end
        acc_w = we && (m_cnt != DEPTH);
        if (we && !acc_w) m_ovf = 1'b1;
        if (rd_valid[sel] === 1'b1 && rr) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pop_empty rl=%0d got=%h exp=none", rl, rd_data[sel]);
            end else begin
                e = sb.pop_front();
                if (rd_data[sel] !== e) begin
                    fails++;
                    $display("FAIL data rl=%0d got=%h exp=%h", rl, rd_data[sel], e);
                end
            end
            m_cnt--;
        end
        if (acc_w) begin
            sb.push_back(wd);
            m_cnt++;
        end
        @(posedge clk);
        #1;
        wr_en[sel]    = 1'b0;
        rd_ready[sel] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n[sel]    = 1'b0;
        wr_en[sel]    = 1'b0;
        rd_ready[sel] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[sel] = 1'b1;
        sb.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        tests++;
        if (rd_valid[sel] !== 1'b0 || wr_ready[sel] !== 1'b1 || count[sel] !== 6'd0 ||
            afull[sel] !== 1'b0 || aempty[sel] !== 1'b1 || ovf[sel] !== 1'b0) begin
            fails++;
            $display("FAIL reset rl=%0d valid=%b rdy=%b count=%0d afull=%b aempty=%b ovf=%b exp 0 1 0 0 1 0",
                     rl, rd_valid[sel], wr_ready[sel], count[sel], afull[sel], aempty[sel], ovf[sel]);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            step(1'b0, 32'h0, 1'b1);
            n++;
        end
        tests++;
        if (sb.size() != 0 || count[sel] !== 6'd0 || rd_valid[sel] !== 1'b0) begin
            fails++;
            $display("FAIL drain rl=%0d left=%0d count=%0d valid=%b exp 0 0 0",
                     rl, sb.size(), count[sel], rd_valid[sel]);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (rd_valid[sel] !== 1'b1 && n < 20) begin
            step(1'b0, 32'h0, 1'b0);
            n++;
        end
        tests++;
        if (rd_valid[sel] !== 1'b1) begin
            fails++;
            $display("FAIL wait_valid rl=%0d valid=%b exp=1", rl, rd_valid[sel]);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_latency();
        do_reset();
        step(1'b1, 32'hA5A5_0001, 1'b0);
        for (int k = 0; k <= rl + 1; k++) begin
            tests++;
            if (rd_valid[sel] !== (k == rl + 1)) begin
                fails++;
                $display("FAIL latency rl=%0d k=%0d valid=%b exp=%b",
                         rl, k, rd_valid[sel], (k == rl + 1));
            end
            if (k <= rl) step(1'b0, 32'h0, 1'b0);
        end
        tests++;
        if (rd_data[sel] !== 32'hA5A5_0001 || count[sel] !== 6'd1) begin
            fails++;
            $display("FAIL first_word rl=%0d data=%h count=%0d exp a5a50001 1",
                     rl, rd_data[sel], count[sel]);
        end
        step(1'b0, 32'h0, 1'b1);
        tests++;
        if (rd_valid[sel] !== 1'b0 || count[sel] !== 6'd0) begin
            fails++;
            $display("FAIL after_pop rl=%0d valid=%b count=%0d exp 0 0",
                     rl, rd_valid[sel], count[sel]);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'(i), 1'b0);
            if (i == AF - 2 || i == AF - 1) begin
                tests++;
                if (afull[sel] !== (i == AF - 1)) begin
                    fails++;
                    $display("FAIL afull rl=%0d count=%0d afull=%b exp=%b",
                             rl, count[sel], afull[sel], (i == AF - 1));
                end
            end
        end
        tests++;
        if (wr_ready[sel] !== 1'b0) begin
            fails++;
            $display("FAIL full_ready rl=%0d rdy=%b exp=0", rl, wr_ready[sel]);
        end
        step(1'b1, 32'hDEAD_0033, 1'b0);
        tests++;
        if (ovf[sel] !== 1'b1 || count[sel] !== 6'(DEPTH)) begin
            fails++;
            $display("FAIL overflow rl=%0d ovf=%b count=%0d exp 1 %0d",
                     rl, ovf[sel], count[sel], DEPTH);
        end
        step(1'b1, 32'hBEEF_0034, 1'b1);
        drain();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 32'(i), 1'b1);
            if (i >= rl + 1) begin
                tests++;
                if (rd_valid[sel] !== 1'b1 || count[sel] !== 6'(rl + 2)) begin
                    fails++;
                    $display("FAIL stream rl=%0d i=%0d valid=%b count=%0d exp 1 %0d",
                             rl, i, rd_valid[sel], count[sel], rl + 2);
                end
            end
        end
        drain();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        drain();
    endtask

    task automatic test_mid_reset();
        int n = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h5000 + 32'(i), 1'b0);
        step(1'b1, 32'hBAD0_BAD0, 1'b0);
        while (m_cnt > 10 && n < 100) begin
            step(1'b0, 32'h0, 1'b1);
            n++;
        end
        do_reset();
        for (int k = 0; k < rl + 3; k++) begin
            step(1'b0, 32'h0, 1'b0);
            tests++;
            if (rd_valid[sel] !== 1'b0) begin
                fails++;
                $display("FAIL stale rl=%0d k=%0d valid=%b exp=0", rl, k, rd_valid[sel]);
            end
        end
        step(1'b1, 32'h1234, 1'b0);
        wait_valid();
        tests++;
        if (rd_data[sel] !== 32'h1234) begin
            fails++;
            $display("FAIL post_reset_head rl=%0d got=%h exp=00001234", rl, rd_data[sel]);
        end
        drain();
    endtask

    task automatic test_empty_pop();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h0, 1'b1);
            tests++;
            if (rd_valid[sel] !== 1'b0 || count[sel] !== 6'd0) begin
                fails++;
                $display("FAIL empty_pop rl=%0d valid=%b count=%0d exp 0 0",
                         rl, rd_valid[sel], count[sel]);
            end
        end
        step(1'b1, 32'hC0DE_000A, 1'b0);
        wait_valid();
        step(1'b1, 32'hC0DE_000B, 1'b1);
        tests++;
        if (count[sel] !== 6'd1) begin
            fails++;
            $display("FAIL pushpop_count rl=%0d count=%0d exp=1", rl, count[sel]);
        end
        wait_valid();
        drain();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d]    = 1'b0;
            wr_en[d]    = 1'b0;
            wr_data[d]  = '0;
            rd_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            rl  = d + 1;
            test_reset();
            test_latency();
            test_fill();
            test_stream();
            test_random();
            test_mid_reset();
            test_empty_pop();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
